// File: rtl/rgb_pkg.sv
// Shared types for the RGB byte link receive path: pixel struct and
// channel-phase state encoding.
package rgb_pkg;

    localparam int RGB_CH_W = 8;

    typedef struct packed {
        logic [RGB_CH_W-1:0] b;
        logic [RGB_CH_W-1:0] g;
        logic [RGB_CH_W-1:0] r;
    } rgb_t;

    typedef enum logic [1:0] {
        EXP_R = 2'd0,
        EXP_G = 2'd1,
        EXP_B = 2'd2
    } unpack_state_e;

endpackage

// File: rtl/rgb_out_stage.sv
// Single-entry valid/ready pixel register; a new pixel may be loaded in the
// same cycle the current one is consumed.
module rgb_out_stage
    import rgb_pkg::*;
#(
    parameter type PIX_T = rgb_t
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  PIX_T load_pix,
    input  logic load_sof,
    output PIX_T out_pix,
    output logic out_sof,
    output logic out_valid,
    input  logic out_ready,
    output logic slot_free
);

    PIX_T pix_r;
    logic sof_r;
    logic valid_r;

    // Pixel slot: load wins over consume, data frozen until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_r   <= '0;
            sof_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (load) begin
            pix_r   <= load_pix;
            sof_r   <= load_sof;
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign slot_free = !valid_r || out_ready;
    assign out_pix   = pix_r;
    assign out_sof   = sof_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/rgb_byte_unpacker.sv
// Rebuilds R,G,B byte triplets into registered pixels, realigning channel
// phase on start-of-frame and counting pixels since the last frame start.
module rgb_byte_unpacker
    import rgb_pkg::*;
#(
    parameter int CH_W       = RGB_CH_W,
    parameter int CNT_W      = 16,
    parameter bit RESYNC_SOF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [CH_W-1:0]  out_r,
    output logic [CH_W-1:0]  out_g,
    output logic [CH_W-1:0]  out_b,
    output logic             out_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sync_err,
    output logic [CNT_W-1:0] pixel_count
);

    typedef struct packed {
        logic [CH_W-1:0] b;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] r;
    } pix_t;

    localparam logic [1:0] ST_EXP_R = EXP_R;
    localparam logic [1:0] ST_EXP_G = EXP_G;
    localparam logic [1:0] ST_EXP_B = EXP_B;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CH_W-1:0]  hold_r_r;
    logic [CH_W-1:0]  hold_g_r;
    logic             hold_sof_r;
    logic             sync_err_r;
    logic [CNT_W-1:0] count_r;

    logic in_fire_s;
    logic resync_s;
    logic take_r_s;
    logic b_fire_s;
    logic out_fire_s;
    logic slot_free_s;
    pix_t load_pix_s;
    pix_t out_pix_s;

    // Only the B byte needs the output slot, so R and G are never stalled.
    assign in_ready   = !reset && ((state_r != ST_EXP_B) || slot_free_s);
    assign in_fire_s  = in_valid && in_ready;
    assign resync_s   = RESYNC_SOF && in_fire_s && in_sof && (state_r != ST_EXP_R);
    assign take_r_s   = in_fire_s && ((state_r == ST_EXP_R) || resync_s);
    assign b_fire_s   = in_fire_s && (state_r == ST_EXP_B) && !resync_s;
    assign out_fire_s = out_valid && out_ready;

    assign load_pix_s.r = hold_r_r;
    assign load_pix_s.g = hold_g_r;
    assign load_pix_s.b = in_data;

    // Channel-phase sequencing; a resync byte restarts the pixel as its R.
    always_comb begin
        state_nx_s = state_r;
        if (resync_s) begin
            state_nx_s = ST_EXP_G;
        end else if (in_fire_s) begin
            case (state_r)
                ST_EXP_R: state_nx_s = ST_EXP_G;
                ST_EXP_G: state_nx_s = ST_EXP_B;
                ST_EXP_B: state_nx_s = ST_EXP_R;
                default:  state_nx_s = ST_EXP_R;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Phase register and the R/G hold registers with the latched sof flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_EXP_R;
            hold_r_r   <= '0;
            hold_g_r   <= '0;
            hold_sof_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (take_r_s) begin
                hold_r_r   <= in_data;
                hold_sof_r <= in_sof;
            end else if (in_fire_s && (state_r == ST_EXP_G)) begin
                hold_g_r <= in_data;
            end
        end
    end

    // Discard pulse and frame-relative pixel counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_err_r <= 1'b0;
            count_r    <= '0;
        end else begin
            sync_err_r <= resync_s;
            if (out_fire_s) begin
                count_r <= out_sof ? CNT_W'(1) : count_r + CNT_W'(1);
            end
        end
    end

    rgb_out_stage #(
        .PIX_T (pix_t)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (b_fire_s),
        .load_pix  (load_pix_s),
        .load_sof  (hold_sof_r),
        .out_pix   (out_pix_s),
        .out_sof   (out_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot_free (slot_free_s)
    );

    assign out_r       = out_pix_s.r;
    assign out_g       = out_pix_s.g;
    assign out_b       = out_pix_s.b;
    assign sync_err    = sync_err_r;
    assign pixel_count = count_r;

endmodule
